// File: rtl/fifo_pack.sv
// Packing FIFO (first-word-fall-through): one DATA_WIDTH word in per write, the two oldest words out per read.
// Optional sticky overflow/underflow flags are built when FIFO_PACK_ERR_EN is defined.
module fifo_pack #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr,
   input  logic                    rd,
   input  logic [DATA_WIDTH-1:0]   w_data,
   output logic [2*DATA_WIDTH-1:0] r_data,
   output logic                    empty,
   output logic                    one_left,
   output logic                    full,
   output logic [ADDR_WIDTH:0]     count
`ifdef FIFO_PACK_ERR_EN
   ,
   output logic                    ovf_err,
   output logic                    unf_err
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0] CNT_TWO  = (ADDR_WIDTH + 1)'(2);
   localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] w_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr_next_word;
   logic                  pair_avail;
   logic                  r_en;
   logic                  w_en;

   // A read needs a complete pair; a full FIFO accepts a write only while a pair leaves.
   assign pair_avail      = (count >= CNT_TWO);
   assign r_en            = rd & pair_avail;
   assign w_en            = wr & (~full | r_en);
   assign r_ptr_next_word = r_ptr + 1'b1;

   assign empty    = (count == '0);
   assign one_left = (count == CNT_ONE);
   assign full     = (count == CNT_FULL);
   assign r_data   = pair_avail ? {mem[r_ptr_next_word], mem[r_ptr]} : '0;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_en) begin
         mem[w_ptr] <= w_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr <= '0;
         r_ptr <= '0;
         count <= '0;
      end else begin
         if (w_en) begin
            w_ptr <= w_ptr + 1'b1;
         end
         if (r_en) begin
            r_ptr <= r_ptr + 2'd2;
         end
         case ({w_en, r_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - CNT_TWO;
            2'b11:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_PACK_ERR_EN
   // Sticky: once a request is dropped the flag holds until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         if (wr & ~w_en) begin
            ovf_err <= 1'b1;
         end
         if (rd & ~r_en) begin
            unf_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_pack.sv
// Directed self-checking bench for fifo_pack (DATA_WIDTH=8, DEPTH=16); define FIFO_PACK_ERR_EN to also check the error flags.
module tb_fifo_pack;

   logic        clk;
   logic        reset;
   logic        wr;
   logic        rd;
   logic [7:0]  w_data;
   logic [15:0] r_data;
   logic        empty;
   logic        one_left;
   logic        full;
   logic [4:0]  count;
`ifdef FIFO_PACK_ERR_EN
   logic        ovf_err;
   logic        unf_err;
`endif

   int check_count = 0;
   int pass_count  = 0;

   fifo_pack #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .rd       (rd),
      .w_data   (w_data),
      .r_data   (r_data),
      .empty    (empty),
      .one_left (one_left),
      .full     (full),
      .count    (count)
`ifdef FIFO_PACK_ERR_EN
      ,
      .ovf_err  (ovf_err),
      .unf_err  (unf_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr = 1'b1;
      w_data = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic pop();
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;
      #12;
      check_count++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b want 1", empty); else pass_count++;
      check_count++; if (count !== 5'd0) $display("[TB] FAIL reset_count: got %0d want 0", count); else pass_count++;
      check_count++; if (one_left !== 1'b0 || full !== 1'b0) $display("[TB] FAIL reset_flags: got one_left=%b full=%b want 0 0", one_left, full); else pass_count++;
      check_count++; if (r_data !== 16'h0000) $display("[TB] FAIL reset_rdata: got %h want 0000", r_data); else pass_count++;
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_pair_write();
      push(8'h11);
      check_count++; if (empty !== 1'b0 || one_left !== 1'b1) $display("[TB] FAIL pw_flags1: got empty=%b one_left=%b want 0 1", empty, one_left); else pass_count++;
      check_count++; if (r_data !== 16'h0000) $display("[TB] FAIL pw_rdata1: got %h want 0000", r_data); else pass_count++;
      push(8'h22);
      check_count++; if (one_left !== 1'b0 || count !== 5'd2) $display("[TB] FAIL pw_state2: got one_left=%b count=%0d want 0 2", one_left, count); else pass_count++;
      check_count++; if (r_data !== 16'h2211) $display("[TB] FAIL pw_rdata2: got %h want 2211", r_data); else pass_count++;
   endtask

   task automatic test_back_to_back_read();
      push(8'h33);
      push(8'h44);
      rd = 1'b1;
      check_count++; if (r_data !== 16'h2211) $display("[TB] FAIL b2b_rd0: got %h want 2211", r_data); else pass_count++;
      tick();
      check_count++; if (r_data !== 16'h4433) $display("[TB] FAIL b2b_rd1: got %h want 4433", r_data); else pass_count++;
      tick();
      rd = 1'b0;
      check_count++; if (empty !== 1'b1 || count !== 5'd0) $display("[TB] FAIL b2b_empty: got empty=%b count=%0d want 1 0", empty, count); else pass_count++;
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) push(8'(i));
      check_count++; if (full !== 1'b1 || count !== 5'd16) $display("[TB] FAIL full_set: got full=%b count=%0d want 1 16", full, count); else pass_count++;
      push(8'hEE);
      check_count++; if (count !== 5'd16 || r_data !== 16'h0100) $display("[TB] FAIL full_drop: got count=%0d r_data=%h want 16 0100", count, r_data); else pass_count++;
`ifdef FIFO_PACK_ERR_EN
      check_count++; if (ovf_err !== 1'b1) $display("[TB] FAIL full_ovf: got %b want 1", ovf_err); else pass_count++;
`endif
      wr = 1'b1; w_data = 8'hAA; rd = 1'b1;
      check_count++; if (r_data !== 16'h0100) $display("[TB] FAIL full_rw_pre: got %h want 0100", r_data); else pass_count++;
      tick();
      wr = 1'b0; rd = 1'b0;
      check_count++; if (count !== 5'd15 || full !== 1'b0) $display("[TB] FAIL full_rw_count: got count=%0d full=%b want 15 0", count, full); else pass_count++;
      for (int i = 0; i < 7; i++) begin
         check_count++;
         if (r_data !== {8'(2 * i + 3), 8'(2 * i + 2)}) $display("[TB] FAIL full_drain%0d: got %h want %h", i, r_data, {8'(2 * i + 3), 8'(2 * i + 2)});
         else pass_count++;
         pop();
      end
      check_count++; if (one_left !== 1'b1 || r_data !== 16'h0000) $display("[TB] FAIL full_lone: got one_left=%b r_data=%h want 1 0000", one_left, r_data); else pass_count++;
      push(8'hBB);
      check_count++; if (r_data !== 16'hBBAA) $display("[TB] FAIL full_aa_kept: got %h want bbaa", r_data); else pass_count++;
      pop();
   endtask

   // Pointers sit at 6 here; cycle 8 words so the next pair is at 14/15 and the one after wraps to 0/1.
   task automatic test_wrap();
      for (int i = 0; i < 8; i++) push(8'hD0 + 8'(i));
      for (int i = 0; i < 4; i++) pop();
      push(8'h5A); push(8'hA5); push(8'h3C); push(8'hC3);
      check_count++; if (r_data !== 16'hA55A) $display("[TB] FAIL wrap_pair_end: got %h want a55a", r_data); else pass_count++;
      pop();
      check_count++; if (r_data !== 16'hC33C) $display("[TB] FAIL wrap_pair_start: got %h want c33c", r_data); else pass_count++;
      pop();
      check_count++; if (empty !== 1'b1) $display("[TB] FAIL wrap_empty: got %b want 1", empty); else pass_count++;
   endtask

   task automatic test_odd_read();
`ifdef FIFO_PACK_ERR_EN
      check_count++; if (unf_err !== 1'b0) $display("[TB] FAIL odd_unf_pre: got %b want 0", unf_err); else pass_count++;
`endif
      push(8'h77);
      wr = 1'b1; w_data = 8'h88; rd = 1'b1;
      tick();
      wr = 1'b0; rd = 1'b0;
      check_count++; if (count !== 5'd2) $display("[TB] FAIL odd_count: got %0d want 2", count); else pass_count++;
      check_count++; if (r_data !== 16'h8877) $display("[TB] FAIL odd_rdata: got %h want 8877", r_data); else pass_count++;
`ifdef FIFO_PACK_ERR_EN
      check_count++; if (unf_err !== 1'b1) $display("[TB] FAIL odd_unf: got %b want 1", unf_err); else pass_count++;
`endif
   endtask

   task automatic test_async_reset();
      push(8'h01); push(8'h02); push(8'h03);
      check_count++; if (count !== 5'd5) $display("[TB] FAIL ar_pre_count: got %0d want 5", count); else pass_count++;
      #2;
      reset = 1'b1;
      #1;
      check_count++; if (empty !== 1'b1 || count !== 5'd0) $display("[TB] FAIL ar_state: got empty=%b count=%0d want 1 0", empty, count); else pass_count++;
      check_count++; if (r_data !== 16'h0000) $display("[TB] FAIL ar_rdata: got %h want 0000", r_data); else pass_count++;
`ifdef FIFO_PACK_ERR_EN
      check_count++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) $display("[TB] FAIL ar_err: got ovf=%b unf=%b want 0 0", ovf_err, unf_err); else pass_count++;
`endif
      @(negedge clk);
      reset = 1'b0;
      tick();
      push(8'h99);
      check_count++; if (dut.mem[0] !== 8'h99) $display("[TB] FAIL ar_addr0: got %h want 99", dut.mem[0]); else pass_count++;
      push(8'h66);
      check_count++; if (r_data !== 16'h6699) $display("[TB] FAIL ar_pair: got %h want 6699", r_data); else pass_count++;
   endtask

   initial begin
      test_reset();
      test_pair_write();
      test_back_to_back_read();
      test_full();
      test_wrap();
      test_odd_read();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
